// File: rtl/dma_xfer_ctrl.sv
// Purpose: splits one DMA descriptor into AXI-legal bursts (<= 2^LEN_W beats, no 4 KB
//          crossing) and streams words between the in/out streams and the engine's native port.
// Latency: start -> first dma_valid in 3 cycles; 2-cycle turnaround between bursts; 1 word/cycle in XFER.
// Backpressure: write stalls on in_valid/dma_ack; read holds dma_valid low while the 1-entry out buffer is full.
//
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_start/i_dir/i_base_addr/i_word_cnt   descriptor (sampled in IDLE only)
//   o_busy/o_done/o_err               status: busy level, done pulse, sticky error
//   i_in_valid/i_in_data/o_in_ready   write-data stream into the block
//   o_out_valid/o_out_data/i_out_ready read-data stream out of the block
//   o_dma_* / i_dma_*                 engine native word port, burst length and burst-ready/error
module dma_xfer_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic                i_dir,
    input  logic [ADDR_W-1:0]   i_base_addr,
    input  logic [CNT_W-1:0]    i_word_cnt,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err,
    input  logic                i_in_valid,
    input  logic [DATA_W-1:0]   i_in_data,
    output logic                o_in_ready,
    output logic                o_out_valid,
    output logic [DATA_W-1:0]   o_out_data,
    input  logic                i_out_ready,
    output logic                o_dma_valid,
    output logic [ADDR_W-1:0]   o_dma_address,
    output logic [DATA_W-1:0]   o_dma_wdata,
    output logic [DATA_W/8-1:0] o_dma_wstrb,
    input  logic [DATA_W-1:0]   i_dma_rdata,
    input  logic                i_dma_ack,
    output logic [LEN_W-1:0]    o_dma_len,
    input  logic                i_dma_idle,
    input  logic                i_dma_error
);

    localparam int CNT1_W = CNT_W + 1;
    localparam logic [CNT1_W-1:0] MAX_BEATS = CNT1_W'(1) << LEN_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_WAIT_ENG,
        S_XFER,
        S_DONE,
        S_ERR
    } state_t;

    state_t              r_state;
    logic                r_dir;
    logic [ADDR_W-1:0]   r_addr;
    logic [CNT_W-1:0]    r_rem;
    logic [CNT1_W-1:0]   r_beats;
    logic [LEN_W-1:0]    r_len;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;

    logic [CNT1_W-1:0]   w_bound_words;
    logic [CNT1_W-1:0]   w_beats;
    logic                w_xfer;
    logic                w_rd_room;
    logic                w_dma_valid;
    logic                w_ack;
    logic                w_rd_ack;
    logic                w_err_evt;
    logic                w_pop;

    // Words left before the next 4 KB page; address bits [1:0] are always zero
    // so the shift is exact. Result spans 1..1024.
    always_comb begin
        w_bound_words = CNT1_W'((13'h1000 - {1'b0, r_addr[11:0]}) >> 2);
        w_beats       = {1'b0, r_rem};
        if (w_bound_words < w_beats) begin
            w_beats = w_bound_words;
        end
        if (MAX_BEATS < w_beats) begin
            w_beats = MAX_BEATS;
        end
    end

    // In XFER with beats==0 a read is only waiting for its last word to drain;
    // no further engine requests may be issued then.
    assign w_xfer      = (r_state == S_XFER) && (r_beats != '0);
    assign w_pop       = r_out_valid && i_out_ready;
    assign w_rd_room   = !r_out_valid || i_out_ready;
    assign w_dma_valid = w_xfer && (r_dir ? i_in_valid : w_rd_room);
    assign w_ack       = w_dma_valid && i_dma_ack;
    assign w_rd_ack    = w_ack && !r_dir;
    assign w_err_evt   = (r_state != S_IDLE) && i_dma_error;

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_err         = r_err;
    assign o_in_ready    = w_xfer && r_dir && i_dma_ack;
    assign o_out_valid   = r_out_valid;
    assign o_out_data    = r_out_data;
    assign o_dma_valid   = w_dma_valid;
    assign o_dma_address = r_addr;
    assign o_dma_wdata   = i_in_data;
    assign o_dma_wstrb   = {(DATA_W/8){r_dir}};
    assign o_dma_len     = r_len;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_dir       <= 1'b0;
            r_addr      <= '0;
            r_rem       <= '0;
            r_beats     <= '0;
            r_len       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_err_evt) begin
                // Error beats any simultaneous final ack: no done pulse.
                r_state <= S_ERR;
                r_err   <= 1'b1;
                r_busy  <= 1'b0;
                r_done  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start) begin
                            r_dir  <= i_dir;
                            r_addr <= i_base_addr & ~ADDR_W'(3);
                            r_rem  <= i_word_cnt;
                            r_err  <= 1'b0;
                            if (i_word_cnt == '0) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= S_CALC;
                                r_busy  <= 1'b1;
                            end
                        end
                    end
                    S_CALC: begin
                        r_len   <= LEN_W'(w_beats - CNT1_W'(1));
                        r_beats <= w_beats;
                        r_state <= S_WAIT_ENG;
                    end
                    S_WAIT_ENG: begin
                        if (i_dma_idle) begin
                            r_state <= S_XFER;
                        end
                    end
                    S_XFER: begin
                        if (w_ack) begin
                            r_addr  <= r_addr + ADDR_W'(4);
                            r_rem   <= r_rem - CNT_W'(1);
                            r_beats <= r_beats - CNT1_W'(1);
                            if (r_beats == CNT1_W'(1)) begin
                                if (r_rem != CNT_W'(1)) begin
                                    r_state <= S_CALC;
                                end else if (r_dir) begin
                                    r_state <= S_DONE;
                                    r_busy  <= 1'b0;
                                    r_done  <= 1'b1;
                                end
                                // A read's final word stays in XFER until popped.
                            end
                        end else if (!r_dir && (r_beats == '0) && w_pop) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    S_ERR: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end

            // One-entry read buffer; refill and pop may coincide.
            if (w_err_evt) begin
                r_out_valid <= 1'b0;
            end else if (w_rd_ack) begin
                r_out_valid <= 1'b1;
                r_out_data  <= i_dma_rdata;
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dma_xfer_ctrl.sv
// Purpose: directed bench for dma_xfer_ctrl with a small engine/stream responder and scoreboard.
// Latency: inputs driven on the falling edge, outputs sampled 1 ns later.
// Backpressure: out_ready stall windows and every-other-cycle engine acks are exercised.
module tb_dma_xfer_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        dir;
    logic [31:0] base_addr;
    logic [15:0] word_cnt;
    logic        busy;
    logic        done;
    logic        err;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        dma_valid;
    logic [31:0] dma_address;
    logic [31:0] dma_wdata;
    logic [3:0]  dma_wstrb;
    logic [31:0] dma_rdata;
    logic        dma_ack;
    logic [7:0]  dma_len;
    logic        dma_idle;
    logic        dma_error;

    int checks = 0;
    int errors = 0;

    logic [31:0] q_addr[$];
    logic [7:0]  q_len[$];
    bit          q_last[$];
    logic [31:0] q_wdata[$];
    logic [31:0] q_rdata[$];

    dma_xfer_ctrl #(.ADDR_W(32), .DATA_W(32), .LEN_W(8), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_dir(dir),
        .i_base_addr(base_addr), .i_word_cnt(word_cnt),
        .o_busy(busy), .o_done(done), .o_err(err),
        .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(in_ready),
        .o_out_valid(out_valid), .o_out_data(out_data), .i_out_ready(out_ready),
        .o_dma_valid(dma_valid), .o_dma_address(dma_address), .o_dma_wdata(dma_wdata),
        .o_dma_wstrb(dma_wstrb), .i_dma_rdata(dma_rdata), .i_dma_ack(dma_ack),
        .o_dma_len(dma_len), .i_dma_idle(dma_idle), .i_dma_error(dma_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected burst split: per-word address, burst length and last-beat marker.
    task automatic model(input logic [31:0] base, input int cnt);
        logic [31:0] a;
        int r;
        int b;
        int beats;
        q_addr.delete(); q_len.delete(); q_last.delete(); q_wdata.delete(); q_rdata.delete();
        a = base & 32'hFFFF_FFFC;
        r = cnt;
        for (int i = 0; i < cnt; i++) q_wdata.push_back(32'hA000_0000 + 32'(i));
        while (r > 0) begin
            b = (4096 - int'(a[11:0])) / 4;
            beats = r;
            if (b < beats) beats = b;
            if (256 < beats) beats = 256;
            for (int k = 0; k < beats; k++) begin
                q_addr.push_back(a);
                q_len.push_back(8'(beats - 1));
                q_last.push_back(k == beats - 1);
                a = a + 32'd4;
            end
            r = r - beats;
        end
    endtask

    task automatic run(input bit d, input logic [31:0] base, input int cnt, input int ack_mode,
                       input int stall_len, input int err_beat, input int rst_beat, input bit poke);
        int cyc, acks, pops, in_hs, wr_idx, rd_idx, done_cnt, valid_seen, stall;
        int done_cyc, err_cyc, rst_cyc, last_ack, last_pop, last_burst_cyc, first_valid, last_evt;
        bit prev_hold, stop;
        logic [31:0] prev_addr;
        cyc = 0; acks = 0; pops = 0; in_hs = 0; wr_idx = 0; rd_idx = 0; done_cnt = 0;
        valid_seen = 0; stall = 0; done_cyc = -1; err_cyc = -1; rst_cyc = -1;
        last_ack = 0; last_pop = 0; last_burst_cyc = -1; first_valid = -1;
        prev_hold = 1'b0; stop = 1'b0; prev_addr = '0;
        model(base, cnt);

        @(negedge clk);
        start = 1'b1; dir = d; base_addr = base; word_cnt = 16'(cnt);
        while (!stop) begin
            @(negedge clk);
            cyc++;
            start = 1'b0; rst = 1'b0; dma_ack = 1'b0; dma_error = 1'b0;
            if (poke && cyc == 4) begin
                start = 1'b1; dir = ~d; base_addr = 32'h0; word_cnt = 16'h0;
            end
            in_valid = d;
            in_data  = 32'hA000_0000 + 32'(wr_idx);
            if (pops >= 1 && stall < stall_len) begin
                out_ready = 1'b0;
                stall++;
            end else begin
                out_ready = 1'b1;
            end
            dma_rdata = 32'hD000_0000 + 32'(rd_idx);
            #1;
            if (cyc == 1) check("err_cleared_on_start", 32'(err), 32'd0);
            if (prev_hold) begin
                check("valid_held", 32'(dma_valid), 32'd1);
                check("addr_held", dma_address, prev_addr);
            end
            if (!d && out_valid && !out_ready) check("valid_while_full", 32'(dma_valid), 32'd0);
            if (dma_valid) begin
                valid_seen++;
                if (first_valid < 0) first_valid = cyc;
                if (last_burst_cyc >= 0) begin
                    check("burst_turnaround", 32'(cyc - last_burst_cyc), 32'd3);
                    last_burst_cyc = -1;
                end
                dma_ack = (ack_mode == 0) || (cyc % 2 == 0);
            end
            if (dma_ack) begin
                acks++;
                if (acks == err_beat) begin dma_error = 1'b1; err_cyc = cyc; end
                if (acks == rst_beat) begin rst = 1'b1; rst_cyc = cyc; end
                if (q_addr.size() == 0) begin
                    check("extra_beat", 32'(acks), 32'(cnt));
                    stop = 1'b1;
                end else begin
                    check("dma_address", dma_address, q_addr.pop_front());
                    check("dma_len", 32'(dma_len), 32'(q_len.pop_front()));
                    if (q_last.pop_front()) last_burst_cyc = cyc;
                    check("dma_wstrb", 32'(dma_wstrb), d ? 32'hF : 32'h0);
                    if (d) check("dma_wdata", dma_wdata, q_wdata.pop_front());
                    else begin
                        q_rdata.push_back(32'hD000_0000 + 32'(rd_idx));
                        rd_idx++;
                    end
                    last_ack = cyc;
                end
            end
            #1;
            check("in_ready", 32'(in_ready), 32'(d && dma_ack));
            if (in_valid && in_ready) begin in_hs++; wr_idx++; end
            if (out_valid && out_ready) begin
                pops++;
                last_pop = cyc;
                if (q_rdata.size() == 0) check("out_extra", 32'(pops), 32'(cnt));
                else check("out_data", out_data, q_rdata.pop_front());
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy_at_done", 32'(busy), 32'd0);
            end
            if (err_cyc >= 0 && cyc == err_cyc + 1) begin
                check("err_valid_drop", 32'(dma_valid), 32'd0);
                check("err_flag", 32'(err), 32'd1);
            end
            prev_hold = dma_valid && !dma_ack;
            prev_addr = dma_address;

            if (rst_cyc >= 0 && cyc == rst_cyc + 1) begin
                check("rst_dma_valid", 32'(dma_valid), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_out_valid", 32'(out_valid), 32'd0);
                check("rst_done", 32'(done), 32'd0);
                check("rst_dma_len", 32'(dma_len), 32'd0);
                check("rst_dma_address", dma_address, 32'd0);
                check("rst_out_data", out_data, 32'd0);
                stop = 1'b1;
            end else if (err_cyc >= 0 && cyc == err_cyc + 3) begin
                stop = 1'b1;
            end else if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                stop = 1'b1;
            end else if (cyc >= 3000) begin
                check("cycle_budget", 32'(cyc), 32'd0);
                stop = 1'b1;
            end
        end

        if (cnt > 0) check("first_valid_cycle", 32'(first_valid), 32'd3);
        if (err_beat > 0) begin
            check("no_done_after_err", 32'(done_cnt), 32'd0);
            check("err_sticky", 32'(err), 32'd1);
        end else if (rst_beat == 0) begin
            last_evt = (cnt == 0) ? 0 : (d ? last_ack : last_pop);
            check("done_count", 32'(done_cnt), 32'd1);
            check("done_latency", 32'(done_cyc), 32'(last_evt + 1));
            check("err_clear", 32'(err), 32'd0);
            if (d) check("in_handshakes", 32'(in_hs), 32'(cnt));
            else   check("out_pops", 32'(pops), 32'(cnt));
            if (cnt == 0) check("no_dma_valid", 32'(valid_seen), 32'd0);
        end

        @(negedge clk);
        start = 1'b0; rst = 1'b0; in_valid = 1'b0; dma_ack = 1'b0; dma_error = 1'b0; out_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dir = 1'b0; base_addr = '0; word_cnt = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        dma_rdata = '0; dma_ack = 1'b0; dma_idle = 1'b1; dma_error = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_dma_valid", 32'(dma_valid), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_dma_len", 32'(dma_len), 32'd0);
        check("reset_dma_address", dma_address, 32'd0);
        check("reset_out_data", out_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single write burst at 0x100, 10 words.
        run(1'b1, 32'h100, 10, 0, 0, 0, 0, 1'b0);
        // 300 words from 0: 256 + 44 split, stray start while busy.
        run(1'b1, 32'h0, 300, 0, 0, 0, 0, 1'b1);
        // Read across the 4 KB page at 0x1000, engine acks every other cycle.
        run(1'b0, 32'hFF8, 8, 1, 0, 0, 0, 1'b0);
        // Read with out_ready held low for 5 cycles after the first pop.
        run(1'b0, 32'h40, 4, 0, 5, 0, 0, 1'b0);
        // Engine error on the third beat of a 10-word write.
        run(1'b1, 32'h200, 10, 0, 0, 3, 0, 1'b0);
        // Zero-length descriptor clears the sticky error and finishes at once.
        run(1'b1, 32'h300, 0, 0, 0, 0, 0, 1'b0);
        // Reset on the fifth beat of a read.
        run(1'b0, 32'h200, 10, 0, 0, 0, 5, 1'b0);
        // Fresh write afterwards, also crossing a page with misaligned base.
        run(1'b1, 32'h0FFE, 3, 0, 0, 0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_xfer_ctrl.md
# dma_xfer_ctrl

Transfer sequencer for the AXI DMA engine. It takes a single descriptor (direction, base address, word count) and splits the transfer into AXI-legal bursts. Each burst is at most 2^LEN_W beats and never crosses a 4 KB boundary. For each burst the block programs the engine's burst length and drives the engine's native word interface from an input stream (write) or into an output stream (read). It sits between the CPU-facing configuration registers and the DMA engine.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, word width; 32 only (4-byte words)
- LEN_W, 8, AXI burst length width; max burst 2^LEN_W beats
- CNT_W, 16, transfer word-count width

- clk  in  1  clock
- rst  in  1  synchronous reset, active-high (one clock; reset is synchronous and active-high)
- start  in  1  launch descriptor; sampled only in IDLE
- dir  in  1  0 = read (memory→out stream), 1 = write (in stream→memory)
- base_addr  in  ADDR_W  start byte address; bits [1:0] ignored (treated as 0)
- word_cnt  in  CNT_W  words to transfer
- busy  out  1  high from the cycle after accepted start until DONE/ERR
- done  out  1  one-cycle pulse on successful completion
- err  out  1  sticky error flag; cleared by next accepted start
- in_valid / in_data / in_ready  in / in DATA_W / out  write-data stream
- out_valid / out_data / out_ready  out / out DATA_W / in  read-data stream
- dma_valid  out  1  native request to engine
- dma_address  out  ADDR_W  word byte address
- dma_wdata  out  DATA_W  = in_data
- dma_wstrb  out  DATA_W/8  all ones for write, all zeros for read
- dma_rdata  in  DATA_W  engine read data
- dma_ack  in  1  engine native ready (per-word completion)
- dma_len  out  LEN_W  burst beats − 1
- dma_idle  in  1  engine burst-ready (engine able to start a new burst)
- dma_error  in  1  engine AXI error

## Operation
- FSM states: IDLE, CALC, WAIT_ENG, XFER, DONE, ERR.
- **IDLE:** on start, latch dir, A = {base_addr[ADDR_W-1:2],2'b00}, R = word_cnt, and clear err.
  - word_cnt = 0 → DONE.
  - Otherwise → CALC.
- **CALC (1 cycle):** B = (4096 − A[11:0]) >> 2 (range 1..1024).
  - beats = min(R, B, 2^LEN_W); all comparisons at CNT_W+1 bits.
  - Register dma_len = beats − 1 and beat counter = beats.
  - → WAIT_ENG.
- **WAIT_ENG:** wait for dma_idle = 1, then → XFER.
- **XFER, write:** dma_valid = in_valid; in_ready = dma_ack; dma_address = A.
- **XFER, read:** dma_valid = 1 while the 1-entry out buffer is empty or is being popped this cycle.
  - On dma_ack, capture dma_rdata into the out buffer and set out_valid.
  - out_valid is held until out_ready.
- **Per dma_ack:** A += 4, R −= 1, beat counter −= 1.
  - When the beat counter reaches 0: → CALC if R ≠ 0, else → DONE.
  - Read: DONE is entered only once the out buffer has drained.
- **DONE (1 cycle):** done = 1, then → IDLE.
- **Error:** dma_error = 1 in any non-IDLE state → ERR.
  - ERR sets err = 1, clears dma_valid, and discards the out buffer.
  - ERR → IDLE next cycle; err stays high.
- **Start while busy:** ignored.
- **dma_len:** stable from the CALC exit until the burst's last dma_ack.
- **dma_valid:** once asserted, it and dma_address stay stable until dma_ack.
  - Write relies on in_valid holding until in_ready.

## Timing
- **Reset values:** state = IDLE. busy, done, err, dma_valid, out_valid, in_ready = 0. dma_len, dma_address, out_data = 0.
- **Reset mid-transfer:** all outputs return to reset values on the cycle after rst is sampled. No done pulse.
- **Latency:** start accepted at cycle 0 → CALC at cycle 1 → WAIT_ENG at cycle 2 → earliest dma_valid at cycle 3 if dma_idle = 1.
- **Throughput:** one word per cycle during XFER when the engine acks every cycle and the stream side is not stalling.
- **Burst turnaround:** 2 cycles (CALC + WAIT_ENG, minimum) between the last dma_ack and the next burst's first dma_valid.
- **Completion:** done rises 1 cycle after the final dma_ack (write) or after the final out handshake (read). busy falls in the same cycle done rises.
- **Simultaneous events:**
  - dma_error on the same cycle as the last dma_ack → ERR wins; no done.
  - Read: out_ready and dma_ack in the same cycle → buffer popped and refilled, out_valid stays 1.

## Test plan
- **Single burst write:** dir=1, base=0x100, cnt=10, engine acks every cycle → dma_len=9; addresses 0x100..0x124; 10 in handshakes; one done pulse; err=0.
- **Max-length split:** dir=1, base=0x0, cnt=300 → two bursts, dma_len=255 then 43; second burst starts at 0x400; done once.
- **4 KB boundary read:** dir=0, base=0xFF8, cnt=8 → burst len=1 at 0xFF8/0xFFC, then len=5 at 0x1000..0x1014; out stream carries the 8 rdata words in order.
- **Backpressure:** read cnt=4 with out_ready low for 5 cycles after the first word → dma_valid low while the buffer is full; no data lost or duplicated; done only after the 4th pop.
- **Error and zero-length:** dma_error pulse during beat 3 of a 10-word write → dma_valid drops next cycle, err=1, no done. Next start with cnt=0 → err cleared, done pulses 1 cycle after start, no dma_valid.
- **Reset mid-burst:** rst during beat 5 → dma_valid, busy, out_valid = 0 next cycle; a fresh start afterwards completes normally.
